// File: rtl/icache_pkg.sv
// icache_pkg: shared types and widths for the direct-mapped instruction cache.
// Supplies fallback values for the XLEN / ICACHE_IDX_W macros when the
// project-wide global_params.v header has not already defined them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ICACHE_IDX_W
`define ICACHE_IDX_W 6
`endif

package icache_pkg;

    localparam int unsigned XLEN = `XLEN;

    // Outstanding memory-controller instruction request tracker.
    typedef enum logic {
        REQ_IDLE = 1'b0,
        REQ_PEND = 1'b1
    } req_state_e;

endpackage

// File: rtl/icache_storage.sv
// icache_storage: valid/tag/data arrays for the instruction cache.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (clears valid bits)
//   rd_idx          - combinational read index
//   rd_valid_c/rd_tag_c/rd_data_c - combinational read data
//   we, wr_idx, wr_tag, wr_data   - synchronous write port
module icache_storage
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned TAG_W  = 25,
    parameter int unsigned DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid_c,
    output logic [TAG_W-1:0]  rd_tag_c,
    output logic [DATA_W-1:0] rd_data_c,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    // Single write port; a fill overwrites whatever held the index.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    // Only the valid bits need reset; tag/data are qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // No write-through bypass: a fill is visible the following cycle.
    assign rd_valid_c = valid_q[rd_idx];
    assign rd_tag_c   = tag_q[rd_idx];
    assign rd_data_c  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, halfword-keyed instruction cache for the fetcher.
// Zero-latency combinational hit lookup on fet_pc; tracks one outstanding
// memory-controller fetch and fills the array when the word returns.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   fet_icache_enable, fet_pc      - lookup request
//   fet_mem_enable                 - fetcher launches a memory fetch for fet_pc
//   mem_inst_ready, mem_inst       - memory controller return path
//   icache_ready, icache_inst      - combinational hit / word (0 on miss)
//   stall, icache_hit_cnt, icache_miss_cnt - only with ICACHE_STATS_EN
// Optional feature macro: ICACHE_STATS_EN (hit/miss counters).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ICACHE_IDX_W
`define ICACHE_IDX_W 6
`endif

module icache
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W = `ICACHE_IDX_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            fet_icache_enable,
    input  logic [XLEN-1:0] fet_pc,
    input  logic            fet_mem_enable,
    input  logic            mem_inst_ready,
    input  logic [XLEN-1:0] mem_inst,
    output logic            icache_ready,
    output logic [XLEN-1:0] icache_inst
`ifdef ICACHE_STATS_EN
    ,
    input  logic            stall,
    output logic [31:0]     icache_hit_cnt,
    output logic [31:0]     icache_miss_cnt
`endif
);

    localparam int unsigned TAG_W = XLEN - IDX_W - 1;

    req_state_e      state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            fill_we;
    logic            req_accept;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0]  rd_data;
    logic             hit;

    // Bit 0 of a PC never selects anything: entries are halfword keyed.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{fet_pc[0], req_pc_q[0]};

    assign lk_idx = fet_pc[IDX_W:1];
    assign lk_tag = fet_pc[XLEN-1:IDX_W+1];

    icache_storage #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (XLEN)
    ) u_storage (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (lk_idx),
        .rd_valid_c (rd_valid),
        .rd_tag_c   (rd_tag),
        .rd_data_c  (rd_data),
        .we         (fill_we),
        .wr_idx     (req_pc_q[IDX_W:1]),
        .wr_tag     (req_pc_q[XLEN-1:IDX_W+1]),
        .wr_data    (mem_inst)
    );

    // Hit compare; lookup is live even while rdy is low.
    assign hit          = fet_icache_enable && rd_valid && (rd_tag == lk_tag);
    assign icache_ready = hit;
    assign icache_inst  = hit ? rd_data : '0;

    // Request tracker. A new request while PEND is only taken together with
    // the return of the old one; otherwise it is a protocol violation and dropped.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        fill_we    = 1'b0;
        req_accept = 1'b0;
        if (rdy) begin
            case (state_q)
                REQ_IDLE: begin
                    if (fet_mem_enable) begin
                        state_d    = REQ_PEND;
                        req_pc_d   = fet_pc;
                        req_accept = 1'b1;
                    end
                end
                REQ_PEND: begin
                    if (mem_inst_ready) begin
                        fill_we = 1'b1;
                        if (fet_mem_enable) begin
                            req_pc_d   = fet_pc;
                            req_accept = 1'b1;
                        end else begin
                            state_d = REQ_IDLE;
                        end
                    end
                end
                default: state_d = REQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ_IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rdy && hit && !stall) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (req_accept) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign icache_hit_cnt  = hit_cnt_q;
    assign icache_miss_cnt = miss_cnt_q;
`endif

endmodule
